ball_packet_tx: RTL and testbench
=================================

Name: ball_packet_tx

Overview:
Downstream of the game controller. On each ball-send pulse it snapshots the outgoing ball state and packs it into a 5-byte packet. It then drives the packet into the board's I2C master, byte by byte, over a valid/ready stream. The byte layout matches the peer board's slave registers y0, y1, Yspeed, gravity and ballspeed, so the peer controller can resume the rally. NACKs and stalls are handled with bounded retries; one further trigger is buffered while a transfer is in flight.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit I2C address of the peer board
MAX_RETRY, 3, re-attempts after the first failed attempt before giving up
BACKOFF_CYCLES, 2500, idle clocks between a failed attempt and its retry (100 us at 25 MHz)
TIMEOUT_CYCLES, 250000, max clocks spent in DATA or WAIT_STOP before the attempt counts as failed

Ports:
clk_25MHZ  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ball_send_trigger  in  1  one-cycle request to send the current ball state
ball_y  in  10  ball y position at the time of the trigger
ball_vy  in  8  signed ball y velocity
gravity_phase  in  2  gravity counter phase
rand_ball  in  2  ball type (0 ping-pong, 1 soccer, 2 basket)
m_start  out  1  one-cycle pulse: master opens a write to m_addr
m_addr  out  7  equals SLAVE_ADDR
m_data  out  8  payload byte, registered
m_valid  out  1  m_data valid
m_ready  in  1  master accepts the byte when m_valid&&m_ready
m_busy  in  1  master is mid-transaction; no m_start is issued while high
m_nack  in  1  one-cycle pulse: slave NACKed
m_done  in  1  one-cycle pulse: STOP completed
tx_busy  out  1  high whenever state!=IDLE
tx_err  out  1  sticky; set when retries are exhausted; cleared when the next packet is loaded
drop_cnt  out  8  count of dropped triggers, saturates at 255
packet_cnt  out  8  count of successfully sent packets, wraps 255->0

Behaviour:
- Reset values: all outputs 0; state IDLE; pending buffer empty; shadow registers, byte index, retry counter and timers all 0.
- Packet bytes are built from the shadow registers:
  - B0 = {y[9:8], 6'b0}
  - B1 = y[7:0]
  - B2 = vy
  - B3 = {6'b0, gravity_phase}
  - B4 = {5'b0, rand_ball, 1'b0}
- Trigger capture:
  - In IDLE with pending empty: the trigger loads the shadow directly.
  - In IDLE with pending full: pending moves to the shadow. A trigger in the same cycle refills pending.
  - In any other state: a trigger fills pending if it is empty. If pending is full, the trigger is dropped and drop_cnt increments, saturating at 255.
- Loading the shadow clears tx_err, the retry counter and the byte index, and moves to REQ.
- States:
  - IDLE: tx_busy=0. Waits for a trigger or a full pending buffer.
  - REQ: waits for m_busy=0, then asserts m_start for exactly one cycle, sets idx=0, clears the timeout timer, and moves to DATA.
  - DATA: m_valid=1 and m_data=B[idx]. On m_valid&&m_ready, idx increments and the next byte appears the following cycle. After the handshake on idx=4, m_valid drops and the state moves to WAIT_STOP. m_data must not change while m_valid=1 and m_ready=0.
  - WAIT_STOP: on m_done, packet_cnt increments and the state returns to IDLE.
  - BACKOFF: counts BACKOFF_CYCLES clocks, then returns to REQ. The packet is resent from B0.
  - FAIL: one cycle with tx_err set, then IDLE. The packet is discarded.
- Failure handling:
  - An attempt fails on m_nack while in DATA or WAIT_STOP, or when the timer reaches TIMEOUT_CYCLES. m_nack takes precedence over a simultaneous handshake or m_done.
  - On failure m_valid drops the same cycle.
  - If retry<MAX_RETRY: retry increments and the state moves to BACKOFF. Otherwise the state moves to FAIL.
  - Total attempts per packet are MAX_RETRY+1.
- Latency: m_start is issued 2 clocks after the trigger when m_busy=0 (trigger->REQ, REQ->m_start).
- reset_n asserted mid-transfer aborts immediately: m_valid=0, m_start=0, pending and shadow cleared.

Test Plan:
- y=10'h2A5, vy=-3 (8'hFD), gravity=2, rand=1; master ready every cycle; m_done 3 clocks after the last byte -> bytes 8'h80, 8'hA5, 8'hFD, 8'h02, 8'h02 in order; packet_cnt=1; tx_busy falls the cycle after m_done.
- m_ready held low 5 cycles on B2 -> m_valid and m_data stay at 8'hFD throughout; no byte is skipped or repeated.
- m_nack during B1 on the first attempt -> m_valid drops; 2500 idle clocks; m_start reissued; full resend from 8'h80; packet_cnt=1; tx_err=0.
- m_nack on all 4 attempts -> exactly 4 m_start pulses; tx_err=1; packet_cnt unchanged; tx_busy=0 after FAIL.
- 3 triggers while busy (y=1, y=2, y=3) -> y=1 is buffered and sent after the current packet; y=2 and y=3 are dropped; drop_cnt=2.
- m_ready=0 for TIMEOUT_CYCLES in DATA -> treated as failure, retry path taken; reset_n pulsed mid-DATA -> all outputs 0 within the same cycle, state IDLE.

Source files
------------

// File: rtl/ball_packet_tx.sv
`timescale 1ns/1ps
// Snapshots the ball state on a send pulse and streams it as a 5-byte packet
// into the I2C master, with bounded retries, backoff and one buffered trigger.
module ball_packet_tx #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h42,
    parameter int         MAX_RETRY      = 3,
    parameter int         BACKOFF_CYCLES = 2500,
    parameter int         TIMEOUT_CYCLES = 250000
) (
    input  logic       clk_25MHZ,
    input  logic       reset_n,
    input  logic       ball_send_trigger,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [1:0] gravity_phase,
    input  logic [1:0] rand_ball,
    output logic       m_start,
    output logic [6:0] m_addr,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic       m_busy,
    input  logic       m_nack,
    input  logic       m_done,
    output logic       tx_busy,
    output logic       tx_err,
    output logic [7:0] drop_cnt,
    output logic [7:0] packet_cnt
);

    localparam int TMAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BACKOFF_LAST = TW'(BACKOFF_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_WAIT_STOP,
        S_BACKOFF,
        S_FAIL
    } state_t;

    state_t        state, next_state;
    logic [9:0]    shadow_y,  pend_y;
    logic [7:0]    shadow_vy, pend_vy;
    logic [1:0]    shadow_g,  pend_g;
    logic [1:0]    shadow_r,  pend_r;
    logic          pend_valid;
    logic [2:0]    idx;
    logic [RW-1:0] retry;
    logic [TW-1:0] timer;

    logic take_trig, take_pend, fill_pend, drop_trig, load;
    logic start_now, handshake, fail_attempt, timed_out, can_retry;

    function automatic logic [7:0] pkt_byte(input logic [2:0] i);
        case (i)
            3'd0:    pkt_byte = {shadow_y[9:8], 6'b0};
            3'd1:    pkt_byte = shadow_y[7:0];
            3'd2:    pkt_byte = shadow_vy;
            3'd3:    pkt_byte = {6'b0, shadow_g};
            3'd4:    pkt_byte = {5'b0, shadow_r, 1'b0};
            default: pkt_byte = 8'h00;
        endcase
    endfunction

    // A buffered trigger always wins over a new one in IDLE; the new one refills the buffer.
    assign take_pend = (state == S_IDLE) && pend_valid;
    assign take_trig = (state == S_IDLE) && !pend_valid && ball_send_trigger;
    assign fill_pend = ball_send_trigger && (take_pend || ((state != S_IDLE) && !pend_valid));
    assign drop_trig = ball_send_trigger && (state != S_IDLE) && pend_valid;
    assign load      = take_pend || take_trig;

    assign timed_out = ((state == S_DATA) || (state == S_WAIT_STOP)) && (timer == TIMEOUT_LAST);
    assign can_retry = retry < RETRY_LIMIT;
    assign start_now = (state == S_REQ) && !m_busy;

    assign m_valid = (state == S_DATA);
    assign tx_busy = (state != S_IDLE);

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        next_state   = state;
        fail_attempt = 1'b0;
        handshake    = 1'b0;
        case (state)
            S_IDLE:    if (load) next_state = S_REQ;
            S_REQ:     if (!m_busy) next_state = S_DATA;
            S_DATA: begin
                if (m_nack || timed_out) begin
                    fail_attempt = 1'b1;
                end else if (m_ready) begin
                    handshake = 1'b1;
                    if (idx == 3'd4) next_state = S_WAIT_STOP;
                end
            end
            S_WAIT_STOP: begin
                if (m_nack || timed_out) fail_attempt = 1'b1;
                else if (m_done)         next_state   = S_IDLE;
            end
            S_BACKOFF: if (timer == BACKOFF_LAST) next_state = S_REQ;
            S_FAIL:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (fail_attempt) next_state = can_retry ? S_BACKOFF : S_FAIL;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            m_start    <= 1'b0;
            m_addr     <= 7'h00;
            m_data     <= 8'h00;
            tx_err     <= 1'b0;
            drop_cnt   <= 8'h00;
            packet_cnt <= 8'h00;
            shadow_y   <= '0;
            shadow_vy  <= '0;
            shadow_g   <= '0;
            shadow_r   <= '0;
            pend_valid <= 1'b0;
            pend_y     <= '0;
            pend_vy    <= '0;
            pend_g     <= '0;
            pend_r     <= '0;
            idx        <= '0;
            retry      <= '0;
            timer      <= '0;
        end else begin
            state   <= next_state;
            m_addr  <= SLAVE_ADDR;
            m_start <= start_now;

            if (take_trig) begin
                shadow_y  <= ball_y;
                shadow_vy <= ball_vy;
                shadow_g  <= gravity_phase;
                shadow_r  <= rand_ball;
            end else if (take_pend) begin
                shadow_y  <= pend_y;
                shadow_vy <= pend_vy;
                shadow_g  <= pend_g;
                shadow_r  <= pend_r;
            end

            if (fill_pend) begin
                pend_valid <= 1'b1;
                pend_y     <= ball_y;
                pend_vy    <= ball_vy;
                pend_g     <= gravity_phase;
                pend_r     <= rand_ball;
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            if (drop_trig && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

            if (load) begin
                tx_err <= 1'b0;
                retry  <= '0;
            end else if (fail_attempt) begin
                if (can_retry) retry  <= retry + RW'(1);
                else           tx_err <= 1'b1;
            end

            // Every attempt restarts from B0; m_data only moves on an accepted byte.
            if (load || start_now) begin
                idx <= 3'd0;
                if (start_now) m_data <= pkt_byte(3'd0);
            end else if (handshake && (idx != 3'd4)) begin
                idx    <= idx + 3'd1;
                m_data <= pkt_byte(idx + 3'd1);
            end

            if (start_now || (fail_attempt && can_retry)) begin
                timer <= '0;
            end else if ((state == S_DATA) || (state == S_WAIT_STOP) || (state == S_BACKOFF)) begin
                timer <= timer + TW'(1);
            end

            if ((state == S_WAIT_STOP) && m_done && !fail_attempt) packet_cnt <= packet_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ball_packet_tx.sv
`timescale 1ns/1ps
// Directed bench for ball_packet_tx: a packet scoreboard holds expected bytes,
// reloaded on each m_start and consumed on each accepted byte.
module tb_ball_packet_tx;

    localparam logic [6:0] SLAVE_ADDR = 7'h42;
    localparam int         BACKOFF    = 2500;
    localparam int         TIMEOUT    = 400;

    logic       clk_25MHZ = 1'b0;
    logic       reset_n;
    logic       ball_send_trigger;
    logic [9:0] ball_y;
    logic [7:0] ball_vy;
    logic [1:0] gravity_phase;
    logic [1:0] rand_ball;
    logic       m_start;
    logic [6:0] m_addr;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_busy;
    logic       m_nack;
    logic       m_done;
    logic       tx_busy;
    logic       tx_err;
    logic [7:0] drop_cnt;
    logic [7:0] packet_cnt;

    ball_packet_tx #(
        .SLAVE_ADDR    (SLAVE_ADDR),
        .MAX_RETRY     (3),
        .BACKOFF_CYCLES(BACKOFF),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_25MHZ        (clk_25MHZ),
        .reset_n          (reset_n),
        .ball_send_trigger(ball_send_trigger),
        .ball_y           (ball_y),
        .ball_vy          (ball_vy),
        .gravity_phase    (gravity_phase),
        .rand_ball        (rand_ball),
        .m_start          (m_start),
        .m_addr           (m_addr),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_busy           (m_busy),
        .m_nack           (m_nack),
        .m_done           (m_done),
        .tx_busy          (tx_busy),
        .tx_err           (tx_err),
        .drop_cnt         (drop_cnt),
        .packet_cnt       (packet_cnt)
    );

    always #20 clk_25MHZ = ~clk_25MHZ;

    logic [39:0] pkt_q[$];
    logic [7:0]  cur_q[$];
    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;
    int pkt_exp   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pack(input logic [9:0] y, input logic [7:0] vy,
                                         input logic [1:0] g, input logic [1:0] r);
        pack = {y[9:8], 6'b0, y[7:0], vy, 6'b0, g, 5'b0, r, 1'b0};
    endfunction

    // Inputs currently driven are what the DUT samples on the coming edge.
    task automatic step();
        logic [39:0] p;
        if (m_valid && m_ready && !m_nack) begin
            check("sb_has_byte", cur_q.size() != 0, 1);
            if (cur_q.size() != 0) check("byte", m_data, cur_q.pop_front());
        end
        @(posedge clk_25MHZ);
        #1;
        if (m_start) begin
            start_cnt++;
            check("m_addr", m_addr, SLAVE_ADDR);
            check("start_has_pkt", pkt_q.size() != 0, 1);
            if (pkt_q.size() != 0) begin
                p = pkt_q[0];
                cur_q.delete();
                for (int i = 0; i < 5; i++) cur_q.push_back(p[39-8*i -: 8]);
            end
        end
    endtask

    task automatic trigger(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                           input logic [1:0] r, input bit sent);
        ball_y = y; ball_vy = vy; gravity_phase = g; rand_ball = r;
        ball_send_trigger = 1'b1;
        if (sent) pkt_q.push_back(pack(y, vy, g, r));
        step();
        ball_send_trigger = 1'b0;
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        m_ready = 1'b0;
        do begin
            step();
            n++;
        end while (!m_start && n < budget);
        check("start_seen", m_start, 1);
    endtask

    // Serves one attempt that has just started; nack_pos/stall_pos < 0 disables them.
    task automatic serve(input int nack_pos, input int stall_pos, input int stall_len);
        int pos = 0;
        int stalls = 0;
        while (pos < 5) begin
            if (pos == nack_pos) begin
                m_ready = 1'b0;
                m_nack  = 1'b1;
                step();
                m_nack  = 1'b0;
                check("valid_drop_on_nack", m_valid, 0);
                return;
            end
            if (pos == stall_pos && stalls < stall_len) begin
                m_ready = 1'b0;
                step();
                stalls++;
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, cur_q[0]);
            end else begin
                m_ready = 1'b1;
                step();
                pos++;
            end
        end
        m_ready = 1'b0;
        check("valid_after_b4", m_valid, 0);
        check("sb_drained", cur_q.size(), 0);
    endtask

    task automatic finish_ok();
        step();
        step();
        check("busy_before_done", tx_busy, 1);
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        check("busy_after_done", tx_busy, 0);
        void'(pkt_q.pop_front());
        pkt_exp = (pkt_exp + 1) % 256;
        check("packet_cnt", packet_cnt, pkt_exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m_start"}, m_start, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_addr"}, m_addr, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_tx_busy"}, tx_busy, 0);
        check({tag, "_tx_err"}, tx_err, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_packet_cnt"}, packet_cnt, 0);
    endtask

    initial begin
        int n;
        int s0;
        int k;
        reset_n = 1'b0;
        ball_send_trigger = 1'b0;
        ball_y = '0; ball_vy = '0; gravity_phase = '0; rand_ball = '0;
        m_ready = 1'b0; m_busy = 1'b0; m_nack = 1'b0; m_done = 1'b0;
        repeat (3) @(posedge clk_25MHZ);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        step();

        // Basic packet, latency and byte order
        trigger(10'h2A5, 8'hFD, 2'd2, 2'd1, 1'b1);
        check("lat_busy", tx_busy, 1);
        check("lat_no_start", m_start, 0);
        wait_start(10, n);
        check("lat_start", n, 1);
        check("first_byte", m_data, 8'h80);
        serve(-1, -1, 0);
        finish_ok();

        // m_busy holds off m_start; stall on B2
        m_busy = 1'b1;
        trigger(10'h155, 8'h07, 2'd1, 2'd2, 1'b1);
        repeat (4) begin
            step();
            check("no_start_busy", m_start, 0);
        end
        m_busy = 1'b0;
        wait_start(10, n);
        check("start_after_busy", n, 1);
        serve(-1, 2, 5);
        finish_ok();

        // NACK on B1, one retry after backoff
        trigger(10'h0F0, 8'h80, 2'd3, 2'd0, 1'b1);
        wait_start(10, n);
        serve(1, -1, 0);
        wait_start(BACKOFF + 10, n);
        check("backoff_len", n, BACKOFF + 1);
        serve(-1, -1, 0);
        finish_ok();
        check("err_after_retry", tx_err, 0);

        // NACK on every attempt
        s0 = start_cnt;
        trigger(10'h3FF, 8'h7F, 2'd0, 2'd2, 1'b1);
        for (int a = 0; a < 4; a++) begin
            wait_start(BACKOFF + 10, n);
            serve(0, -1, 0);
        end
        check("fail_busy", tx_busy, 1);
        check("fail_err", tx_err, 1);
        step();
        check("after_fail_busy", tx_busy, 0);
        check("after_fail_err", tx_err, 1);
        repeat (10) step();
        check("fail_starts", start_cnt - s0, 4);
        check("fail_pkt_cnt", packet_cnt, pkt_exp);
        void'(pkt_q.pop_front());

        // Triggers while busy: one buffered, two dropped
        m_busy = 1'b1;
        trigger(10'h300, 8'h11, 2'd1, 2'd0, 1'b1);
        check("err_cleared", tx_err, 0);
        trigger(10'd1, 8'h21, 2'd2, 2'd1, 1'b1);
        trigger(10'd2, 8'h22, 2'd3, 2'd2, 1'b0);
        trigger(10'd3, 8'h23, 2'd0, 2'd1, 1'b0);
        m_busy = 1'b0;
        wait_start(10, n);
        serve(-1, -1, 0);
        finish_ok();
        wait_start(10, n);
        check("pend_start", n, 2);
        serve(-1, -1, 0);
        finish_ok();
        check("drop_cnt", drop_cnt, 2);

        // Timeout in DATA then successful retry
        trigger(10'h1C3, 8'hC0, 2'd2, 2'd2, 1'b1);
        wait_start(10, n);
        m_ready = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (m_valid && k < TIMEOUT + 10);
        check("timeout_len", k, TIMEOUT);
        check("timeout_busy", tx_busy, 1);
        wait_start(BACKOFF + 10, n);
        check("timeout_backoff", n, BACKOFF + 1);
        serve(-1, -1, 0);
        finish_ok();

        // Reset mid-DATA with a buffered trigger
        m_busy = 1'b1;
        trigger(10'h2A5, 8'hFD, 2'd2, 2'd1, 1'b1);
        trigger(10'h011, 8'h01, 2'd1, 2'd1, 1'b0);
        m_busy = 1'b0;
        wait_start(10, n);
        m_ready = 1'b1;
        step();
        step();
        m_ready = 1'b0;
        #5;
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        pkt_q.delete();
        cur_q.delete();
        pkt_exp = 0;
        @(posedge clk_25MHZ);
        #1;
        reset_n = 1'b1;
        repeat (5) begin
            step();
            check("no_pend_after_reset", tx_busy, 0);
        end
        trigger(10'h0AA, 8'h55, 2'd1, 2'd2, 1'b1);
        wait_start(10, n);
        serve(-1, -1, 0);
        finish_ok();

        // drop_cnt saturation
        m_busy = 1'b1;
        trigger(10'h001, 8'h00, 2'd0, 2'd0, 1'b1);
        for (int i = 0; i < 300; i++) trigger(10'(i), 8'h00, 2'd0, 2'd0, 1'b0);
        check("drop_sat", drop_cnt, 255);
        #5;
        reset_n = 1'b0;
        #1;
        check("drop_reset", drop_cnt, 0);
        check("busy_reset", tx_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
